// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream input, memory bus and status signals of the mem_loader block.
// master = the loader itself, slave = the stream source, memory and status observer.
interface mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    modport master (
        input  start, s_data, s_valid, s_last, readdata,
        output s_ready, address, byteenable, chipselect, write,
        output writedata, busy, done, error, word_count
    );

    modport slave (
        output start, s_data, s_valid, s_last, readdata,
        input  s_ready, address, byteenable, chipselect, write,
        input  writedata, busy, done, error, word_count
    );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: packs a byte stream little-endian into 32-bit words and writes them to memory.
// Optional readback checksum verify is enabled by defining MEM_LOADER_READBACK_EN.
module mem_loader #(
    parameter int ADDR_W    = 10,
    parameter int LAST_ADDR = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, FILL, WRITE, VERIFY, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t            state;
    logic [1:0]        idx;
    logic              last_seen;
    logic              s_ready_q;
    logic              cs_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wd_q;
    logic [ADDR_W:0]   wc_q;

`ifdef MEM_LOADER_READBACK_EN
    logic        error_q;
    logic [31:0] wsum;
    logic [31:0] rsum;
    logic        rd_valid;
`endif

    // Single FSM: all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            last_seen <= 1'b0;
            s_ready_q <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wd_q      <= '0;
            wc_q      <= '0;
`ifdef MEM_LOADER_READBACK_EN
            error_q   <= 1'b0;
            wsum      <= '0;
            rsum      <= '0;
            rd_valid  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_q    <= '0;
                        wc_q      <= '0;
                        idx       <= '0;
                        wd_q      <= '0;
                        be_q      <= '0;
                        last_seen <= 1'b0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= FILL;
`ifdef MEM_LOADER_READBACK_EN
                        error_q   <= 1'b0;
                        wsum      <= '0;
                        rsum      <= '0;
`endif
                    end
                end
                FILL: begin
                    if (bus.s_valid && s_ready_q) begin
                        wd_q[{idx, 3'b000} +: 8] <= bus.s_data;
                        be_q[idx] <= 1'b1;
                        idx       <= idx + 2'd1;
                        // s_last on the 4th byte still yields one full word
                        if (idx == 2'd3 || bus.s_last) begin
                            last_seen <= bus.s_last;
                            s_ready_q <= 1'b0;
                            cs_q      <= 1'b1;
                            wr_q      <= 1'b1;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    cs_q <= 1'b0;
                    wr_q <= 1'b0;
                    wc_q <= wc_q + 1'b1;
                    idx  <= '0;
                    wd_q <= '0;
                    be_q <= '0;
                    if (addr_q != LAST) begin
                        addr_q <= addr_q + 1'b1;
                    end
`ifdef MEM_LOADER_READBACK_EN
                    wsum <= wsum + wd_q;
`endif
                    if (last_seen || addr_q == LAST) begin
`ifdef MEM_LOADER_READBACK_EN
                        addr_q   <= '0;
                        cs_q     <= 1'b1;
                        rd_valid <= 1'b0;
                        state    <= VERIFY;
`else
                        done_q <= 1'b1;
                        state  <= DONE;
`endif
                    end else begin
                        s_ready_q <= 1'b1;
                        state     <= FILL;
                    end
                end
                VERIFY: begin
`ifdef MEM_LOADER_READBACK_EN
                    // readdata lags the address by one cycle
                    if (rd_valid) begin
                        rsum <= rsum + bus.readdata;
                    end
                    rd_valid <= cs_q;
                    if (cs_q) begin
                        if ({1'b0, addr_q} == wc_q - 1'b1) begin
                            cs_q <= 1'b0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end else begin
                        error_q <= error_q |
                            ((rsum + bus.readdata) != wsum);
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.chipselect = cs_q;
    assign bus.write      = wr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.address    = addr_q;
    assign bus.byteenable = be_q;
    assign bus.writedata  = wd_q;
    assign bus.word_count = wc_q;

`ifdef MEM_LOADER_READBACK_EN
    assign bus.error = error_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^bus.readdata;
    assign bus.error       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench for mem_loader with LAST_ADDR=3.
// Expected writes and done events are queued by stimulus and popped by a monitor.
module tb_mem_loader;
    localparam int ADDR_W    = 10;
    localparam int LAST_ADDR = 3;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [3:0]        be;
    } wr_t;

    typedef struct {
        logic [ADDR_W:0] wc;
        logic            err;
    } dn_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    mem_loader_if #(.ADDR_W(ADDR_W)) bus();

    mem_loader #(
        .ADDR_W   (ADDR_W),
        .LAST_ADDR(LAST_ADDR)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [31:0] mem [0:1023];
    bit          corrupt = 1'b0;
    wr_t         wq[$];
    dn_t         dq[$];
    logic [7:0]  bq[$];
    int          checks   = 0;
    int          errors   = 0;
    int          acc      = 0;
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: one-cycle read latency, optional corruption of word 1.
    always @(posedge clk) begin
        if (bus.chipselect && bus.write) begin
            mem[bus.address] <= (corrupt && bus.address == 1) ?
                (bus.writedata ^ 32'h100) : bus.writedata;
        end
        bus.readdata <= mem[bus.address];
    end

    // Monitor: count handshakes, check writes and done against the queues.
    always @(negedge clk) begin
        wr_t e;
        dn_t f;
        if (bus.s_valid && bus.s_ready) acc++;
        if (bus.write) chk("write_vs_ready", 32'(bus.s_ready), 0);
        if (bus.chipselect && bus.write) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h",
                         bus.address, bus.writedata);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", 32'(bus.address), 32'(e.a));
                chk("wr_data", bus.writedata, e.d);
                chk("wr_be", 32'(bus.byteenable), 32'(e.be));
            end
        end
        if (bus.done) begin
            done_cnt++;
            chk("done_busy", 32'(bus.busy), 1);
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: word_count %0d",
                         bus.word_count);
            end else begin
                f = dq.pop_front();
                chk("done_word_count", 32'(bus.word_count), 32'(f.wc));
                chk("done_error", 32'(bus.error), 32'(f.err));
            end
        end
    end

    task automatic exp_wr(input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        wr_t e;
        e.a  = a;
        e.d  = d;
        e.be = be;
        wq.push_back(e);
    endtask

    task automatic exp_done(input logic [ADDR_W:0] wc, input logic err);
        dn_t f;
        f.wc  = wc;
        f.err = err;
        dq.push_back(f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit l, output bit ok);
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int k = 0;
        while (done_cnt == prev && k < 100) begin
            tick();
            k++;
        end
        chk("done_seen", done_cnt, prev + 1);
        tick();
        tick();
    endtask

    task automatic load(input bit gap);
        bit ok;
        int p = done_cnt;
        do_start();
        for (int i = 0; i < bq.size(); i++) begin
            send(bq[i], i == bq.size() - 1, ok);
            chk("byte_accepted", 32'(ok), 1);
            if (gap) tick();
        end
        wait_done(p);
    endtask

    task automatic check_idle_outputs();
        chk("rst_s_ready", 32'(bus.s_ready), 0);
        chk("rst_chipselect", 32'(bus.chipselect), 0);
        chk("rst_write", 32'(bus.write), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_address", 32'(bus.address), 0);
        chk("rst_byteenable", 32'(bus.byteenable), 0);
        chk("rst_writedata", bus.writedata, 0);
        chk("rst_word_count", 32'(bus.word_count), 0);
    endtask

    initial begin
        bit ok;
        int p;
        int a0;
        int stop;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bus.start   = 1'b0;
        bus.s_data  = 8'h0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check_idle_outputs();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Single full word with s_last on the 4th byte
        exp_wr(0, 32'h44332211, 4'hF);
        exp_done(1, 1'b0);
        bq = {8'h11, 8'h22, 8'h33, 8'h44};
        load(1'b0);

        // Six bytes: one full word and one partial word
        exp_wr(0, 32'h04030201, 4'hF);
        exp_wr(1, 32'h00000605, 4'b0011);
        exp_done(2, 1'b0);
        bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        load(1'b0);

        // Same six bytes with s_valid gaps
        exp_wr(0, 32'h04030201, 4'hF);
        exp_wr(1, 32'h00000605, 4'b0011);
        exp_done(2, 1'b0);
        load(1'b1);

        // Single byte word
        exp_wr(0, 32'h000000AB, 4'b0001);
        exp_done(1, 1'b0);
        bq = {8'hAB};
        load(1'b0);

        // Twenty bytes against LAST_ADDR=3
        exp_wr(0, 32'h04030201, 4'hF);
        exp_wr(1, 32'h08070605, 4'hF);
        exp_wr(2, 32'h0C0B0A09, 4'hF);
        exp_wr(3, 32'h100F0E0D, 4'hF);
        exp_done(4, 1'b0);
        p    = done_cnt;
        a0   = acc;
        stop = 20;
        do_start();
        for (int i = 0; i < 20; i++) begin
            send(8'(i + 1), 1'b0, ok);
            if (!ok) begin
                stop = i;
                break;
            end
        end
        chk("last_addr_stop_index", stop, 16);
        chk("last_addr_accepted", acc - a0, 16);
        chk("last_addr_unaccepted", 20 - (acc - a0), 4);
        wait_done(p);
        chk("last_addr_s_ready", 32'(bus.s_ready), 0);

        // Reset after two bytes, then a fresh load from address 0
        do_start();
        send(8'hA1, 1'b0, ok);
        send(8'hA2, 1'b0, ok);
        reset_n = 1'b0;
        #1;
        check_idle_outputs();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        exp_wr(0, 32'h88776655, 4'hF);
        exp_done(1, 1'b0);
        bq = {8'h55, 8'h66, 8'h77, 8'h88};
        load(1'b0);

`ifdef MEM_LOADER_READBACK_EN
        // Corrupted word 1 must raise error, a clean memory must not
        corrupt = 1'b1;
        exp_wr(0, 32'h13121110, 4'hF);
        exp_wr(1, 32'h17161514, 4'hF);
        exp_done(2, 1'b1);
        bq = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        load(1'b0);
        chk("readback_error_sticky", 32'(bus.error), 1);
        corrupt = 1'b0;
        exp_wr(0, 32'h13121110, 4'hF);
        exp_wr(1, 32'h17161514, 4'hF);
        exp_done(2, 1'b0);
        load(1'b0);
`endif

        repeat (4) tick();
        chk("writes_left", wq.size(), 0);
        chk("dones_left", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The parameter ADDR_W SHALL default to 10 and set the memory word-address width.
REQ-002 The parameter LAST_ADDR SHALL default to 1023 and set the highest word address the block writes.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all logic is rising-edge.
REQ-004 The port reset_n SHALL be an input, 1 bit wide, and be an asynchronous, active-low reset.
REQ-005 The port start SHALL be an input, 1 bit wide, and carry a one-cycle pulse that begins a load.
REQ-006 The port s_data SHALL be an input, 8 bits wide, and carry the byte-stream data.
REQ-007 The port s_valid SHALL be an input, 1 bit wide, and qualify s_data.
REQ-008 The port s_last SHALL be an input, 1 bit wide, and mark the final byte of the stream.
REQ-009 The port s_ready SHALL be an output, 1 bit wide; a byte is accepted when s_valid and s_ready are both high in the same cycle.
REQ-010 The port address SHALL be an output, ADDR_W bits wide, and carry the memory word address.
REQ-011 The port byteenable SHALL be an output, 4 bits wide, and carry the memory byte lanes.
REQ-012 The port chipselect SHALL be an output, 1 bit wide, and select the memory.
REQ-013 The port write SHALL be an output, 1 bit wide, and request a memory write.
REQ-014 The port writedata SHALL be an output, 32 bits wide, and carry the memory write data.
REQ-015 The port readdata SHALL be an input, 32 bits wide, and carry memory read data valid one cycle after the address is presented.
REQ-016 The port busy SHALL be an output, 1 bit wide, and be high whenever the state is not IDLE.
REQ-017 The port done SHALL be an output, 1 bit wide, and carry a one-cycle pulse when a load completes.
REQ-018 The port error SHALL be an output, 1 bit wide, and be a sticky readback-mismatch flag.
REQ-019 The port word_count SHALL be an output, ADDR_W+1 bits wide, and hold the number of words written in the current or last load.

Function
REQ-020 The state machine SHALL have the states IDLE, FILL, WRITE, VERIFY and DONE.
REQ-021 In IDLE, a start pulse SHALL clear address, word_count, the byte index and error, and move to FILL; start SHALL be ignored in every other state.
REQ-022 s_ready SHALL be high only in FILL.
REQ-023 Accepted bytes SHALL pack little-endian: byte index 0 to writedata[7:0], and index 3 to writedata[31:24].
REQ-024 In FILL, acceptance of the 4th byte or of any byte with s_last high SHALL move the machine to WRITE on the next edge.
REQ-025 WRITE SHALL last exactly one cycle with chipselect=1 and write=1, and byteenable SHALL have one bit set per byte received (4'b0001, 4'b0011, 4'b0111 or 4'b1111).
REQ-026 Unreceived byte lanes of writedata SHALL be 0.
REQ-027 After WRITE, word_count SHALL increment by 1 and the byte index SHALL clear.
REQ-028 After WRITE, address SHALL increment by 1, except when the write was at LAST_ADDR.
REQ-029 After WRITE, the machine SHALL go to VERIFY if READBACK is enabled, otherwise to DONE, when s_last was seen or address equalled LAST_ADDR; otherwise it SHALL return to FILL.
REQ-030 When LAST_ADDR is written without s_last, the remaining stream SHALL be left unaccepted.
REQ-031 DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-032 Outside WRITE and VERIFY, chipselect and write SHALL be 0.
REQ-033 A byte-count boundary within one cycle SHALL always be resolved by s_last taking effect together with the 4th byte, producing one full write.

Reset
REQ-034 While reset_n is low, the state SHALL be IDLE and s_ready, chipselect, write, busy, done and error SHALL be 0.
REQ-035 While reset_n is low, address, byteenable, writedata and word_count SHALL be 0.
REQ-036 Reset asserted mid-load SHALL abort the load immediately with no further memory access; a partial word SHALL be discarded.

Configuration
REQ-037 With MEM_LOADER_READBACK_EN defined, the block SHALL keep a 32-bit wrap-around sum of all written writedata.
REQ-038 With MEM_LOADER_READBACK_EN defined, VERIFY SHALL present addresses 0 to word_count-1 with chipselect=1 and write=0, one per cycle.
REQ-039 With MEM_LOADER_READBACK_EN defined, VERIFY SHALL sum readdata sampled one cycle after each address, then set error if the read sum differs from the write sum, then go to DONE.
REQ-040 Without MEM_LOADER_READBACK_EN, VERIFY SHALL be unreachable, readdata SHALL be ignored, and error SHALL be constant 0.

Verification
REQ-041 A bench SHALL cover: start, then bytes 11 22 33 44 with s_last on 44 -> one write at address 0, writedata 0x44332211, byteenable 4'hF, done one cycle later, word_count=1.
REQ-042 A bench SHALL cover: 6 bytes 01..06 with s_last on 06 -> writes 0x04030201/4'hF at 0 and 0x00000605/4'b0011 at 1, word_count=2.
REQ-043 A bench SHALL cover: LAST_ADDR=3 with 20 bytes streamed -> exactly 4 writes at addresses 0 to 3, done asserted, s_ready low afterwards, and 4 bytes left unaccepted.
REQ-044 A bench SHALL cover: s_valid toggling every other cycle -> identical writes to the gap-free case, with the WRITE cycle never overlapping s_ready.
REQ-045 A bench SHALL cover: reset_n pulled low after 2 bytes -> all outputs 0 at once, no write issued, and a fresh start loads from address 0.
REQ-046 A bench SHALL cover, with MEM_LOADER_READBACK_EN: the model memory corrupts word 1 -> error=1 at done; with a clean memory -> error=0.
